bus_mem_responder: RTL

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/sysbus_pkg.sv | 26 ++
 rtl/bus_mem_array.sv | 25 ++
 rtl/bus_mem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: opcodes, tag field positions and the responder FSM states.
package sysbus_pkg;

  localparam logic [3:0] SYSBUS_READ   = 4'h1;
  localparam logic [3:0] SYSBUS_WRITE  = 4'h2;
  localparam logic       SYSBUS_MEMORY = 1'b1;

  localparam int TAG_TARGET_BIT = 12;
  localparam int TAG_OP_MSB     = 11;
  localparam int TAG_OP_LSB     = 8;

  localparam int LINE_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_DELAY,
    ST_RESP,
    ST_WDATA
  } resp_state_e;

  function automatic logic is_mem_request(input logic target, input logic [3:0] opcode);
    return (target == SYSBUS_MEMORY) && ((opcode == SYSBUS_READ) || (opcode == SYSBUS_WRITE));
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Backing store for the bus memory responder: one shared address, synchronous write, asynchronous read.
module bus_mem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage array is deliberately not reset, so its contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_mem_responder.sv
// System-bus memory responder: critical-word-first 8-beat line reads and 8-beat line writes.
// Backing-store updates on writes are enabled by defining BUS_MEM_RESPONDER_WRITE_EN.
module bus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam int LINE_AW = WORD_AW - 3;
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);

  resp_state_e               state_q;
  logic [LINE_AW-1:0]        line_q;
  logic [2:0]                start_q;
  logic [2:0]                beat_q;
  logic [LAT_W-1:0]          delay_q;
  logic                      is_write_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic                      reqack_q;
  logic                      respcyc_q;
  logic [BUS_DATA_WIDTH-1:0] resp_q;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q;

  logic                      req_valid;
  logic [3:0]                req_op;
  logic [2:0]                word_off;
  logic [WORD_AW-1:0]        mem_addr;
  logic                      mem_we;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;
  logic                      unused_addr_bits;

  assign req_op    = bus_reqtag[TAG_OP_MSB:TAG_OP_LSB];
  assign req_valid = is_mem_request(bus_reqtag[TAG_TARGET_BIT], req_op);

  // Only the word index selects storage; byte offset and bits above the array alias away.
  assign unused_addr_bits = ^{bus_req[2:0], bus_req[BUS_DATA_WIDTH-1:3+WORD_AW]};

  // In RESP the array is already addressing the beat that follows the one on the bus.
  always_comb begin
    word_off = start_q;
    if (state_q == ST_RESP) begin
      word_off = start_q + beat_q + 3'd1;
    end else if (state_q == ST_WDATA) begin
      word_off = start_q + beat_q;
    end
  end

  assign mem_addr = {line_q, word_off};

`ifdef BUS_MEM_RESPONDER_WRITE_EN
  assign mem_we = (state_q == ST_WDATA) && bus_reqcyc;
`else
  assign mem_we = 1'b0;
`endif

  bus_mem_array #(
    .WIDTH (BUS_DATA_WIDTH),
    .DEPTH (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (bus_req),
    .rdata_o (mem_rdata)
  );

  // NOTE: every register in this block is assigned with <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      start_q    <= '0;
      beat_q     <= '0;
      delay_q    <= '0;
      is_write_q <= 1'b0;
      tag_q      <= '0;
      reqack_q   <= 1'b0;
      respcyc_q  <= 1'b0;
      resp_q     <= '0;
      resptag_q  <= '0;
    end else begin
      reqack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus_reqcyc && req_valid) begin
            line_q     <= bus_req[3+WORD_AW-1:6];
            start_q    <= bus_req[5:3];
            tag_q      <= bus_reqtag;
            is_write_q <= (req_op == SYSBUS_WRITE);
            beat_q     <= '0;
            delay_q    <= '0;
            reqack_q   <= 1'b1;
            state_q    <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_q <= is_write_q ? ST_WDATA : ST_DELAY;
        end
        ST_DELAY: begin
          if (delay_q == LAT_W'(READ_LATENCY - 1)) begin
            state_q   <= ST_RESP;
            respcyc_q <= 1'b1;
            resp_q    <= mem_rdata;
            resptag_q <= tag_q;
            beat_q    <= '0;
          end else begin
            delay_q <= delay_q + 1'b1;
          end
        end
        ST_RESP: begin
          // respcyc_q is always high here, so respack alone marks a consumed beat.
          if (bus_respack) begin
            if (is_write_q || (beat_q == 3'(LINE_WORDS - 1))) begin
              state_q   <= ST_IDLE;
              respcyc_q <= 1'b0;
              resp_q    <= '0;
              resptag_q <= '0;
              beat_q    <= '0;
            end else begin
              beat_q <= beat_q + 3'd1;
              resp_q <= mem_rdata;
            end
          end
        end
        ST_WDATA: begin
          if (bus_reqcyc) begin
            if (beat_q == 3'(LINE_WORDS - 1)) begin
              state_q   <= ST_RESP;
              respcyc_q <= 1'b1;
              resp_q    <= '0;
              resptag_q <= tag_q;
              beat_q    <= '0;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

endmodule
